ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single memory_ram port between two bus masters: M0 = riscv_32i_ia data port, M1 = UART loader/DMA.
//  Accepts one request at a time and drives one RAM access with a configurable wait-state count.
//  Returns write acknowledge or registered read data to the granted master only.
//  Sits between the masters and memory_ram in socriscv32, replacing the direct core-to-RAM wiring.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  WAIT_STATES 0   extra cycles RAM_CE/RD/WR are held before sampling (0..15)
//  FIXED_PRIO  0   0 = round-robin between M0/M1; 1 = M0 always wins ties
// PORTS
//  iCLK       in   1   system clock, rising edge
//  iRST       in   1   asynchronous, active-low reset
//  iM0_REQ    in   1   M0 request; held high until oM0_ACK
//  iM0_WR     in   1   M0 direction: 1 = write, 0 = read
//  iM0_ADDR   in   AW  M0 address
//  iM0_WDATA  in   DW  M0 write data
//  oM0_RDATA  out  DW  M0 read data, valid while oM0_ACK=1
//  oM0_ACK    out  1   M0 one-cycle completion pulse
//  iM1_*/oM1_*         identical set for M1
//  oRAM_CE    out  1   RAM chip enable
//  oRAM_RD    out  1   RAM read enable
//  oRAM_WR    out  1   RAM write enable
//  oRAM_ADDR  out  AW  RAM address
//  oRAM_DATA  out  DW  RAM write data
//  iRAM_DATA  in   DW  RAM read data, valid the cycle after RD is sampled
//  oGNT       out  2   one-hot current owner {M1,M0}; 00 when idle
//  oBUSY      out  1   1 in ACCESS or RESP
// BEHAVIOUR
//  Reset (iRST=0, async): state=IDLE; every output = 0; last-grant pointer = M1, so M0 wins first tie.
//  All outputs are registered. Masters keep ADDR/WR/WDATA stable from REQ rise until ACK.
//  FSM states IDLE, ACCESS, RESP:
//  - IDLE: sample REQs on the clock edge.
//    - None asserted: stay.
//    - One asserted: grant it.
//    - Both asserted: FIXED_PRIO=1 grants M0; otherwise grant the master not in the last-grant pointer.
//    - On grant: latch owner, WR, ADDR, WDATA; load wait counter = WAIT_STATES; set oGNT; go to ACCESS.
//  - ACCESS: oRAM_CE=1, oRAM_RD=~WR, oRAM_WR=WR, ADDR/DATA from the latch.
//    - Counter > 0: decrement and stay.
//    - Counter = 0: go to RESP; CE/RD/WR drop to 0 on that edge.
//    - The RAM therefore sees exactly WAIT_STATES+1 enable cycles per access.
//  - RESP: owner's oMx_ACK=1 for exactly one cycle.
//    - On a read, oMx_RDATA is captured from iRAM_DATA on the edge entering RESP.
//    - On a write, RDATA is held at its previous value.
//    - Update the last-grant pointer; go to IDLE; oGNT returns to 00 in IDLE.
//  Latency: REQ seen at edge N; ACCESS during N+1..N+1+WAIT_STATES; ACK in the following cycle.
//    - WAIT_STATES=0 gives ACK 2 cycles after the sampling edge, i.e. 3 cycles per access.
//  Non-owner: ACK stays 0; its request waits and is re-arbitrated in the next IDLE.
//  REQ dropped mid-transaction: ignored; the access completes and ACK is still issued.
//  Round-robin guarantees no master waits more than one other access when both hold REQ.
//  Reset asserted mid-ACCESS: RAM enables drop immediately; no ACK is issued; a partial write is not retried.
// TESTING
//  1 Reset: iRST=0 mid-ACCESS -> oRAM_CE/WR, oGNT, oBUSY, both ACKs = 0 immediately; first tie afterwards goes to M0.
//  2 M0 write then read, WAIT_STATES=0:
//    - Write ADDR=0x10, WDATA=0xDEADBEEF -> one-cycle RAM_WR, oM0_ACK 2 cycles after the sampling edge.
//    - Read of 0x10 -> oM0_RDATA=0xDEADBEEF with ACK.
//  3 Both REQ held continuously, FIXED_PRIO=0 -> grants alternate M0,M1,M0,M1; each ACK every 6 cycles.
//  4 FIXED_PRIO=1, both REQ held -> M0 granted every time; M1 granted only after M0 drops REQ.
//  5 WAIT_STATES=3, M1 read of 0x20 -> oRAM_RD high exactly 4 cycles; oM1_ACK 5 cycles after the sampling edge.
//  6 M0 drops REQ during ACCESS -> ACK still pulses once; the next IDLE grants pending M1.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Lets two bus masters share one single-port RAM. M0 is the CPU data port and M1 is the
//   loader/DMA. The arbiter takes one request at a time and runs one RAM access with
//   WAIT_STATES extra enable cycles. It then returns a one-cycle ACK, plus the registered
//   read data on a read, to the master that owned the access.
//
// Parameters
//   AW, DW       address / data width
//   WAIT_STATES  extra cycles the RAM enables are held before sampling (0..15)
//   FIXED_PRIO   0: round-robin on ties, 1: M0 always wins ties
//
// Ports (all outputs registered)
//   iCLK, iRST                 clock, asynchronous active-low reset
//   iMx_REQ/WR/ADDR/WDATA      master x request, direction (1 = write), address, write data
//   oMx_RDATA, oMx_ACK         master x read data (valid with ACK), one-cycle completion pulse
//   oRAM_CE/RD/WR              RAM enables, high for WAIT_STATES+1 cycles per access
//   oRAM_ADDR, oRAM_DATA       RAM address / write data from the request latch
//   iRAM_DATA                  RAM read data, captured on the last access cycle
//   oGNT                       one-hot owner {M1,M0}, 00 when idle
//   oBUSY                      high while an access or its response is in progress
module ram_port_arbiter #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FIXED_PRIO  = 0
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iM0_REQ,
  input  logic          iM0_WR,
  input  logic [AW-1:0] iM0_ADDR,
  input  logic [DW-1:0] iM0_WDATA,
  output logic [DW-1:0] oM0_RDATA,
  output logic          oM0_ACK,
  input  logic          iM1_REQ,
  input  logic          iM1_WR,
  input  logic [AW-1:0] iM1_ADDR,
  input  logic [DW-1:0] iM1_WDATA,
  output logic [DW-1:0] oM1_RDATA,
  output logic          oM1_ACK,
  output logic          oRAM_CE,
  output logic          oRAM_RD,
  output logic          oRAM_WR,
  output logic [AW-1:0] oRAM_ADDR,
  output logic [DW-1:0] oRAM_DATA,
  input  logic [DW-1:0] iRAM_DATA,
  output logic [1:0]    oGNT,
  output logic          oBUSY
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  // Wait counter is 4 bits wide, so WAIT_STATES is limited to 0..15.
  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  state_e        r_state;
  logic [3:0]    r_cnt;
  logic          r_owner_m1;  // owner of the access in flight
  logic          r_last_m1;   // last completed grant; resets to M1 so M0 wins the first tie
  logic          r_dir_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          r_m0_ack;
  logic          r_m1_ack;
  logic          r_ram_ce;
  logic          r_ram_rd;
  logic          r_ram_wr;
  logic [1:0]    r_gnt;
  logic          r_busy;

  logic          w_any_req;
  logic          w_pick_m1;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // Arbitration: on a tie, round-robin picks whichever master did not win last time.
  always_comb begin
    w_any_req = iM0_REQ | iM1_REQ;
    if (iM0_REQ && iM1_REQ) begin
      w_pick_m1 = (FIXED_PRIO == 0) && !r_last_m1;
    end else begin
      w_pick_m1 = iM1_REQ;
    end
    w_sel_wr    = w_pick_m1 ? iM1_WR    : iM0_WR;
    w_sel_addr  = w_pick_m1 ? iM1_ADDR  : iM0_ADDR;
    w_sel_wdata = w_pick_m1 ? iM1_WDATA : iM0_WDATA;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_owner_m1 <= 1'b0;
      r_last_m1  <= 1'b1;
      r_dir_wr   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_ram_ce   <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_gnt      <= 2'b00;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner_m1 <= w_pick_m1;
            r_dir_wr   <= w_sel_wr;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_cnt      <= WaitInit;
            r_gnt      <= w_pick_m1 ? 2'b10 : 2'b01;
            r_busy     <= 1'b1;
            r_ram_ce   <= 1'b1;
            r_ram_rd   <= ~w_sel_wr;
            r_ram_wr   <= w_sel_wr;
            r_state    <= StAccess;
          end
        end
        StAccess: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Last enable cycle: drop the RAM strobes and capture read data on this edge.
            r_ram_ce <= 1'b0;
            r_ram_rd <= 1'b0;
            r_ram_wr <= 1'b0;
            if (r_owner_m1) begin
              r_m1_ack <= 1'b1;
              if (!r_dir_wr) r_m1_rdata <= iRAM_DATA;
            end else begin
              r_m0_ack <= 1'b1;
              if (!r_dir_wr) r_m0_rdata <= iRAM_DATA;
            end
            r_state <= StResp;
          end
        end
        StResp: begin
          r_m0_ack  <= 1'b0;
          r_m1_ack  <= 1'b0;
          r_last_m1 <= r_owner_m1;
          r_gnt     <= 2'b00;
          r_busy    <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign oM0_RDATA = r_m0_rdata;
  assign oM0_ACK   = r_m0_ack;
  assign oM1_RDATA = r_m1_rdata;
  assign oM1_ACK   = r_m1_ack;
  assign oRAM_CE   = r_ram_ce;
  assign oRAM_RD   = r_ram_rd;
  assign oRAM_WR   = r_ram_wr;
  assign oRAM_ADDR = r_addr;
  assign oRAM_DATA = r_wdata;
  assign oGNT      = r_gnt;
  assign oBUSY     = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter. Instance A: WAIT_STATES=0, round-robin.
// Instance B: WAIT_STATES=3, fixed priority.
// Each instance has a small RAM model: synchronous write and combinational read.
// Expected ACKs go into a per-instance queue when a request is driven.
// A negedge monitor pops each entry and checks master, cycle and read data.
module tb_ram_port_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int          NI  = 2;
  localparam int unsigned WsA = 0;
  localparam int unsigned WsB = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          m0_req   [NI];
  logic          m0_wr    [NI];
  logic [AW-1:0] m0_addr  [NI];
  logic [DW-1:0] m0_wdata [NI];
  logic [DW-1:0] m0_rdata [NI];
  logic          m0_ack   [NI];
  logic          m1_req   [NI];
  logic          m1_wr    [NI];
  logic [AW-1:0] m1_addr  [NI];
  logic [DW-1:0] m1_wdata [NI];
  logic [DW-1:0] m1_rdata [NI];
  logic          m1_ack   [NI];
  logic          ram_ce   [NI];
  logic          ram_rd   [NI];
  logic          ram_wr   [NI];
  logic [AW-1:0] ram_addr [NI];
  logic [DW-1:0] ram_wdat [NI];
  logic [DW-1:0] ram_rdat [NI];
  logic [1:0]    gnt      [NI];
  logic          busy     [NI];

  ram_port_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WsA), .FIXED_PRIO(0)) u_dut_a (
    .iCLK(clk), .iRST(rst_n),
    .iM0_REQ(m0_req[0]), .iM0_WR(m0_wr[0]), .iM0_ADDR(m0_addr[0]), .iM0_WDATA(m0_wdata[0]),
    .oM0_RDATA(m0_rdata[0]), .oM0_ACK(m0_ack[0]),
    .iM1_REQ(m1_req[0]), .iM1_WR(m1_wr[0]), .iM1_ADDR(m1_addr[0]), .iM1_WDATA(m1_wdata[0]),
    .oM1_RDATA(m1_rdata[0]), .oM1_ACK(m1_ack[0]),
    .oRAM_CE(ram_ce[0]), .oRAM_RD(ram_rd[0]), .oRAM_WR(ram_wr[0]),
    .oRAM_ADDR(ram_addr[0]), .oRAM_DATA(ram_wdat[0]), .iRAM_DATA(ram_rdat[0]),
    .oGNT(gnt[0]), .oBUSY(busy[0])
  );

  ram_port_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WsB), .FIXED_PRIO(1)) u_dut_b (
    .iCLK(clk), .iRST(rst_n),
    .iM0_REQ(m0_req[1]), .iM0_WR(m0_wr[1]), .iM0_ADDR(m0_addr[1]), .iM0_WDATA(m0_wdata[1]),
    .oM0_RDATA(m0_rdata[1]), .oM0_ACK(m0_ack[1]),
    .iM1_REQ(m1_req[1]), .iM1_WR(m1_wr[1]), .iM1_ADDR(m1_addr[1]), .iM1_WDATA(m1_wdata[1]),
    .oM1_RDATA(m1_rdata[1]), .oM1_ACK(m1_ack[1]),
    .oRAM_CE(ram_ce[1]), .oRAM_RD(ram_rd[1]), .oRAM_WR(ram_wr[1]),
    .oRAM_ADDR(ram_addr[1]), .oRAM_DATA(ram_wdat[1]), .iRAM_DATA(ram_rdat[1]),
    .oGNT(gnt[1]), .oBUSY(busy[1])
  );

  // RAM models
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  always @(posedge clk) if (ram_ce[0] && ram_wr[0]) mem_a[ram_addr[0][7:0]] <= ram_wdat[0];
  always @(posedge clk) if (ram_ce[1] && ram_wr[1]) mem_b[ram_addr[1][7:0]] <= ram_wdat[1];
  assign ram_rdat[0] = mem_a[ram_addr[0][7:0]];
  assign ram_rdat[1] = mem_b[ram_addr[1][7:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            mst;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  typedef struct {
    int            mst;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  exp_t          sb_a [$];
  exp_t          sb_b [$];
  int            checks   = 0;
  int            failures = 0;
  int            ce_cnt [NI];
  int            rd_cnt [NI];
  int            wr_cnt [NI];
  logic [DW-1:0] rd_model [NI][2];
  bit            last_m1  [NI];
  vec_t          vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? int'(WsA) : int'(WsB);
  endfunction

  function automatic logic ack_of(input int i, input int m);
    return (m == 0) ? m0_ack[i] : m1_ack[i];
  endfunction

  function automatic logic [DW-1:0] rdata_of(input int i, input int m);
    return (m == 0) ? m0_rdata[i] : m1_rdata[i];
  endfunction

  task automatic check_ack(input int i, input int m);
    exp_t e;
    int   n;
    n = (i == 0) ? sb_a.size() : sb_b.size();
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_ack inst%0d: M%0d ack with nothing expected (cycle %0d)", i, m,
               cyc);
      return;
    end
    if (i == 0) e = sb_a.pop_front();
    else e = sb_b.pop_front();
    chk($sformatf("ack_master_i%0d", i), 64'(m), 64'(e.mst));
    chk($sformatf("ack_cycle_i%0d_m%0d", i, m), 64'(cyc), 64'(e.cyc));
    chk($sformatf("ack_rdata_i%0d_m%0d", i, m), 64'(rdata_of(i, m)), 64'(e.rdata));
  endtask

  // Monitor: counts RAM enable cycles and checks every ACK against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ram_ce[i]) ce_cnt[i] <= ce_cnt[i] + 1;
      if (ram_rd[i]) rd_cnt[i] <= rd_cnt[i] + 1;
      if (ram_wr[i]) wr_cnt[i] <= wr_cnt[i] + 1;
      for (int m = 0; m < 2; m++) begin
        if (ack_of(i, m)) check_ack(i, m);
      end
    end
  end

  task automatic drive(input int i, input int m, input logic req, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (m == 0) begin
      m0_req[i] = req; m0_wr[i] = wr; m0_addr[i] = addr; m0_wdata[i] = wdata;
    end else begin
      m1_req[i] = req; m1_wr[i] = wr; m1_addr[i] = addr; m1_wdata[i] = wdata;
    end
  endtask

  // A write leaves the master's RDATA unchanged; a read updates it.
  task automatic expect_txn(input int i, input int m, input logic wr,
                            input logic [DW-1:0] exp_rd, input int ack_cyc);
    exp_t e;
    if (!wr) rd_model[i][m] = exp_rd;
    e.mst = m; e.rdata = rd_model[i][m]; e.cyc = ack_cyc;
    if (i == 0) sb_a.push_back(e);
    else sb_b.push_back(e);
  endtask

  task automatic wait_ack(input int i, input int m, input string tag);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      got = ack_of(i, m);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no ack within 40 cycles, expected one", tag);
    end
  endtask

  // Single transaction from idle. Drive at a negedge: the next posedge samples the request.
  // The ACK is then seen WAIT_STATES+2 negedges later.
  task automatic do_req(input int i, input int m, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                        input string tag);
    int ce0, rd0, wr0, n;
    n = ws_of(i) + 1;
    ce0 = ce_cnt[i]; rd0 = rd_cnt[i]; wr0 = wr_cnt[i];
    drive(i, m, 1'b1, wr, addr, wdata);
    expect_txn(i, m, wr, exp_rd, cyc + 2 + ws_of(i));
    last_m1[i] = (m == 1);
    wait_ack(i, m, tag);
    drive(i, m, 1'b0, 1'b0, '0, '0);
    chk({tag, "_ce_cycles"}, 64'(ce_cnt[i] - ce0), 64'(n));
    chk({tag, "_rd_cycles"}, 64'(rd_cnt[i] - rd0), 64'(wr ? 0 : n));
    chk({tag, "_wr_cycles"}, 64'(wr_cnt[i] - wr0), 64'(wr ? n : 0));
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_ctrl_i%0d", tag, i),
          64'({ram_ce[i], ram_rd[i], ram_wr[i], m0_ack[i], m1_ack[i], busy[i], gnt[i]}), 64'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int first;
    int mk;

    for (int i = 0; i < NI; i++) begin
      drive(i, 0, 1'b0, 1'b0, '0, '0);
      drive(i, 1, 1'b0, 1'b0, '0, '0);
      rd_model[i][0] = '0;
      rd_model[i][1] = '0;
      last_m1[i] = 1'b1;
    end
    vecs[0] = '{0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0};
    vecs[3] = '{1, 1'b0, 32'h20, 32'h0,         32'hCAFE_F00D};
    vecs[4] = '{0, 1'b0, 32'h20, 32'h0,         32'hCAFE_F00D};
    vecs[5] = '{0, 1'b1, 32'h10, 32'h1234_5678, 32'h0};
    vecs[6] = '{0, 1'b0, 32'h10, 32'h0,         32'h1234_5678};
    vecs[7] = '{1, 1'b0, 32'h10, 32'h0,         32'h1234_5678};

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_rdata_i%0d", i), 64'({m0_rdata[i], m1_rdata[i]}), 64'(0));
      chk($sformatf("reset_ram_bus_i%0d", i), 64'({ram_addr[i], ram_wdat[i]}), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single transactions on A (WAIT_STATES=0)
    for (int v = 0; v < 8; v++) begin
      do_req(0, vecs[v].mst, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rd,
             $sformatf("vec%0d", v));
    end
    chk("vec_sb_drained", 64'(sb_a.size()), 64'(0));

    // Both masters hold REQ on A: grants alternate, 3 cycles apart
    first = last_m1[0] ? 0 : 1;
    drive(0, 0, 1'b1, 1'b1, 32'h40, 32'h1111_1111);
    drive(0, 1, 1'b1, 1'b0, 32'h20, 32'h0);
    s = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      mk = ((k % 2) == 0) ? first : 1 - first;
      expect_txn(0, mk, (mk == 0), 32'hCAFE_F00D, s + 3 * k + 1);
    end
    last_m1[0] = ((first == 0) ? 1 : 0) == 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      mk = ((k % 2) == 0) ? first : 1 - first;
      chk($sformatf("rr_gnt_%0d", k), 64'(gnt[0]), 64'((mk == 1) ? 2 : 1));
      chk($sformatf("rr_busy_%0d", k), 64'(busy[0]), 64'(1));
      repeat ((k == 3) ? 2 : 3) @(negedge clk);
    end
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rr_sb_drained", 64'(sb_a.size()), 64'(0));
    chk("rr_idle_gnt", 64'(gnt[0]), 64'(0));

    // M0 drops REQ mid-access while M1 becomes pending
    drive(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
    s = cyc + 1;
    expect_txn(0, 0, 1'b0, 32'h1234_5678, s + 1);
    @(negedge clk);
    chk("drop_gnt_m0", 64'(gnt[0]), 64'(1));
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b1, 1'b1, 32'h50, 32'h5555_AAAA);
    expect_txn(0, 1, 1'b1, 32'h0, s + 4);
    repeat (3) @(negedge clk);
    chk("drop_gnt_m1", 64'(gnt[0]), 64'(2));
    @(negedge clk);
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("drop_sb_drained", 64'(sb_a.size()), 64'(0));

    // WAIT_STATES=3 on B: preload 0x20, then an M1 read with 4 RD cycles
    do_req(1, 0, 1'b1, 32'h20, 32'hA5A5_0020, 32'h0, "ws3_wr");
    do_req(1, 1, 1'b0, 32'h20, 32'h0, 32'hA5A5_0020, "ws3_rd");

    // FIXED_PRIO=1 on B: M0 wins every tie until it drops REQ
    drive(1, 0, 1'b1, 1'b1, 32'h30, 32'h0000_0030);
    drive(1, 1, 1'b1, 1'b0, 32'h20, 32'h0);
    s = cyc + 1;
    for (int k = 0; k < 3; k++) expect_txn(1, 0, 1'b1, 32'h0, s + 6 * k + 4);
    expect_txn(1, 1, 1'b0, 32'hA5A5_0020, s + 22);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fp_gnt_m0_%0d", k), 64'(gnt[1]), 64'(1));
      repeat ((k == 2) ? 4 : 6) @(negedge clk);
    end
    drive(1, 0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    chk("fp_gnt_m1", 64'(gnt[1]), 64'(2));
    repeat (4) @(negedge clk);
    drive(1, 1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("fp_sb_drained", 64'(sb_b.size()), 64'(0));

    // Leave A's last grant on M0 so the post-reset tie shows the pointer was reset
    do_req(0, 0, 1'b0, 32'h10, 32'h0, 32'h1234_5678, "pre_rst");

    // Reset in the middle of a B write access
    drive(1, 0, 1'b1, 1'b1, 32'h60, 32'hBAD0_BAD0);
    repeat (2) @(negedge clk);
    chk("midrst_pre_ce", 64'({ram_ce[1], ram_wr[1], busy[1]}), 64'(7));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    drive(1, 0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < NI; i++) begin
      rd_model[i][0] = '0;
      rd_model[i][1] = '0;
      last_m1[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First tie after reset goes to M0, then round-robin to M1
    drive(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(0, 1, 1'b1, 1'b0, 32'h20, 32'h0);
    s = cyc + 1;
    expect_txn(0, 0, 1'b0, 32'h1234_5678, s + 1);
    expect_txn(0, 1, 1'b0, 32'hCAFE_F00D, s + 4);
    @(negedge clk);
    chk("post_rst_tie_m0", 64'(gnt[0]), 64'(1));
    repeat (4) @(negedge clk);
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    chk("post_rst_sb_drained", 64'(sb_a.size()), 64'(0));
    chk("final_sb_b_drained", 64'(sb_b.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
